atm_keypad_frontend: RTL and testbench

ATM_KEYPAD_FRONTEND -- requirements
Module: atm_keypad_frontend

---
 rtl/atm_keypad_if.sv | 30 +++
 rtl/atm_keypad_frontend.sv | 221 ++++++++++++++++++++++
 tb/tb_atm_keypad_frontend.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/atm_keypad_if.sv
// Signal bundle between the ATM keypad front end, the keypad scanner and the ATM core.
// The master modport belongs to atm_keypad_frontend. The slave modport is the keypad and core side.
interface atm_keypad_if;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        req_ready;
    logic        rsp_valid;
    logic        rsp_error;
    logic        lang;
    logic [11:0] accNumber;
    logic [3:0]  pin;
    logic [11:0] destinationAccNumber;
    logic [2:0]  menuOption;
    logic [10:0] amount;
    logic        req_valid;
    logic        entry_error;
    logic        timeout;

    modport master (
        input  key_valid, key_code, req_ready, rsp_valid, rsp_error,
        output lang, accNumber, pin, destinationAccNumber, menuOption, amount,
               req_valid, entry_error, timeout
    );

    modport slave (
        output key_valid, key_code, req_ready, rsp_valid, rsp_error,
        input  lang, accNumber, pin, destinationAccNumber, menuOption, amount,
               req_valid, entry_error, timeout
    );
endinterface

// File: rtl/atm_keypad_frontend.sv
// ATM keypad front end: builds account, PIN, menu, amount and destination fields from key strobes.
// It issues one request to the ATM core. Define ATM_KEYPAD_TIMEOUT_EN to enable the keypad inactivity abort.
module atm_keypad_frontend #(
    parameter int unsigned TIMEOUT_CYCLES = 100,
    parameter int unsigned MAX_AMOUNT     = 2047
) (
    input logic          clk,
    input logic          rst,
    atm_keypad_if.master kp_io
);
    localparam logic [3:0]  KEY_ENTER  = 4'hA;
    localparam logic [3:0]  KEY_CLEAR  = 4'hB;
    localparam logic [3:0]  KEY_CANCEL = 4'hC;
    localparam logic [3:0]  KEY_LANG   = 4'hD;
    localparam logic [16:0] ACC_LIMIT  = 17'd4095;
    localparam logic [16:0] AMT_LIMIT  = 17'(MAX_AMOUNT);

    if (TIMEOUT_CYCLES == 0 || MAX_AMOUNT == 0 || MAX_AMOUNT > 2047) begin : g_param_chk
        $error("atm_keypad_frontend: TIMEOUT_CYCLES must be >= 1 and MAX_AMOUNT in 1..2047");
    end

    typedef enum logic [2:0] {
        IDLE, ACC_ENTRY, PIN_ENTRY, MENU_SEL, AMT_ENTRY, DEST_ENTRY, ISSUE, WAIT_RESP
    } state_t;

    state_t      state_q;
    logic        lang_q;
    logic [11:0] acc_q;
    logic [3:0]  pin_q;
    logic [11:0] dest_q;
    logic [2:0]  menu_q;
    logic [10:0] amt_q;
    logic        req_valid_q;
    logic        err_q;
    logic        tmo_q;
    logic [2:0]  dcnt_q;

    logic        key_hit;
    logic        is_digit;
    logic        in_entry;
    logic        cancel_hit;
    logic        rsp_fail;
    logic        tmo_hit;
    logic        field_ovf;
    logic [11:0] field_cur;
    logic [16:0] field_lim;
    logic [16:0] field_d;

    assign key_hit    = kp_io.key_valid;
    assign is_digit   = kp_io.key_code <= 4'd9;
    assign in_entry   = state_q inside {ACC_ENTRY, PIN_ENTRY, MENU_SEL, AMT_ENTRY, DEST_ENTRY};
    assign cancel_hit = key_hit && in_entry && (kp_io.key_code == KEY_CANCEL);
    assign rsp_fail   = (state_q == WAIT_RESP) && kp_io.rsp_valid && kp_io.rsp_error;

    // One shared accumulator serves whichever numeric field the current state edits.
    always_comb begin
        field_cur = acc_q;
        field_lim = ACC_LIMIT;
        case (state_q)
            AMT_ENTRY: begin
                field_cur = {1'b0, amt_q};
                field_lim = AMT_LIMIT;
            end
            DEST_ENTRY: field_cur = dest_q;
            default: ;
        endcase
        field_d   = 17'(field_cur) * 17'd10 + 17'(kp_io.key_code);
        field_ovf = (dcnt_q == 3'd4) || (field_d > field_lim);
    end

`ifdef ATM_KEYPAD_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_q;

    // Reloaded by any key or by being outside the entry states, so a state change always restarts it.
    assign tmo_hit = in_entry && !key_hit && (idle_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_q <= '0;
        end else if (!in_entry || key_hit) begin
            idle_q <= TW'(TIMEOUT_CYCLES - 1);
        end else if (idle_q != '0) begin
            idle_q <= idle_q - TW'(1);
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lang_q      <= 1'b0;
            acc_q       <= '0;
            pin_q       <= '0;
            dest_q      <= '0;
            menu_q      <= '0;
            amt_q       <= '0;
            req_valid_q <= 1'b0;
            err_q       <= 1'b0;
            tmo_q       <= 1'b0;
            dcnt_q      <= '0;
        end else begin
            err_q <= 1'b0;
            tmo_q <= tmo_hit;
            if (key_hit && (kp_io.key_code == KEY_LANG)) begin
                lang_q <= ~lang_q;
            end
            case (state_q)
                IDLE: begin
                    if (key_hit && is_digit) begin
                        state_q <= ACC_ENTRY;
                        acc_q   <= 12'(kp_io.key_code);
                        dcnt_q  <= 3'd1;
                    end
                end
                ACC_ENTRY, AMT_ENTRY, DEST_ENTRY: begin
                    if (key_hit && is_digit) begin
                        err_q  <= field_ovf;
                        dcnt_q <= field_ovf ? 3'd0 : dcnt_q + 3'd1;
                        case (state_q)
                            ACC_ENTRY: acc_q  <= field_ovf ? 12'd0 : field_d[11:0];
                            AMT_ENTRY: amt_q  <= field_ovf ? 11'd0 : field_d[10:0];
                            default:   dest_q <= field_ovf ? 12'd0 : field_d[11:0];
                        endcase
                    end else if (key_hit && (kp_io.key_code == KEY_ENTER)) begin
                        if (dcnt_q == 3'd0) begin
                            err_q <= 1'b1;
                        end else begin
                            dcnt_q <= 3'd0;
                            if (state_q == ACC_ENTRY) begin
                                state_q <= PIN_ENTRY;
                            end else if ((state_q == AMT_ENTRY) && (menu_q == 3'd6)) begin
                                state_q <= DEST_ENTRY;
                            end else begin
                                state_q     <= ISSUE;
                                req_valid_q <= 1'b1;
                            end
                        end
                    end else if (key_hit && (kp_io.key_code == KEY_CLEAR)) begin
                        dcnt_q <= 3'd0;
                        case (state_q)
                            ACC_ENTRY: acc_q  <= '0;
                            AMT_ENTRY: amt_q  <= '0;
                            default:   dest_q <= '0;
                        endcase
                    end
                end
                PIN_ENTRY: begin
                    if (key_hit && is_digit) begin
                        pin_q  <= kp_io.key_code;
                        dcnt_q <= 3'd1;
                    end else if (key_hit && (kp_io.key_code == KEY_ENTER)) begin
                        if (dcnt_q == 3'd0) begin
                            err_q <= 1'b1;
                        end else begin
                            dcnt_q  <= 3'd0;
                            state_q <= MENU_SEL;
                        end
                    end else if (key_hit && (kp_io.key_code == KEY_CLEAR)) begin
                        pin_q  <= '0;
                        dcnt_q <= 3'd0;
                    end
                end
                MENU_SEL: begin
                    if (key_hit && is_digit) begin
                        if (kp_io.key_code == 4'd3) begin
                            menu_q      <= 3'd3;
                            state_q     <= ISSUE;
                            req_valid_q <= 1'b1;
                        end else if ((kp_io.key_code >= 4'd4) && (kp_io.key_code <= 4'd7)) begin
                            menu_q  <= kp_io.key_code[2:0];
                            state_q <= AMT_ENTRY;
                            dcnt_q  <= 3'd0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (req_valid_q && kp_io.req_ready) begin
                        req_valid_q <= 1'b0;
                        state_q     <= WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    if (kp_io.rsp_valid && !kp_io.rsp_error) begin
                        state_q <= MENU_SEL;
                        menu_q  <= '0;
                        amt_q   <= '0;
                        dest_q  <= '0;
                        dcnt_q  <= 3'd0;
                    end
                end
                default: state_q <= IDLE;
            endcase
            // Session aborts override anything decided above; lang survives them.
            if (cancel_hit || rsp_fail || tmo_hit) begin
                state_q     <= IDLE;
                acc_q       <= '0;
                pin_q       <= '0;
                dest_q      <= '0;
                menu_q      <= '0;
                amt_q       <= '0;
                dcnt_q      <= 3'd0;
                req_valid_q <= 1'b0;
            end
        end
    end

    assign kp_io.lang                 = lang_q;
    assign kp_io.accNumber            = acc_q;
    assign kp_io.pin                  = pin_q;
    assign kp_io.destinationAccNumber = dest_q;
    assign kp_io.menuOption           = menu_q;
    assign kp_io.amount               = amt_q;
    assign kp_io.req_valid            = req_valid_q;
    assign kp_io.entry_error          = err_q;
    assign kp_io.timeout              = tmo_q;
endmodule

// File: tb/tb_atm_keypad_frontend.sv
// Scoreboard bench for atm_keypad_frontend: a session-level model predicts errors and requests.
// A monitor pops and compares those predictions whenever the DUT pulses or hands off a request.
module tb_atm_keypad_frontend;
    localparam int TMO  = 100;
    localparam int MAXA = 2047;
    localparam int P_IDLE = 0, P_ACC = 1, P_PIN = 2, P_MENU = 3, P_AMT = 4, P_DEST = 5, P_ISSUE = 6, P_WAIT = 7;
    localparam int EV_ERR = 0, EV_TMO = 1, EV_REQ = 2;

    typedef struct {
        int kind;
        int acc;
        int pin;
        int dest;
        int menu;
        int amt;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    atm_keypad_if kp();

    atm_keypad_frontend #(.TIMEOUT_CYCLES(TMO), .MAX_AMOUNT(MAXA)) dut (
        .clk   (clk),
        .rst   (rst),
        .kp_io (kp.master)
    );

    always #5 clk = ~clk;

    int  n_checks = 0;
    int  n_fail   = 0;
    ev_t exp_q[$];
    int  m_phase, m_acc, m_pin, m_dest, m_menu, m_amt, m_lang, m_digits;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void push_ev(input int kind);
        ev_t e;
        e.kind = kind; e.acc = m_acc; e.pin = m_pin;
        e.dest = m_dest; e.menu = m_menu; e.amt = m_amt;
        exp_q.push_back(e);
    endfunction

    function automatic void m_clear_all();
        m_acc = 0; m_pin = 0; m_dest = 0; m_menu = 0; m_amt = 0;
        m_digits = 0; m_phase = P_IDLE;
    endfunction

    function automatic int enter_digit(input int cur, input int d, input int lim);
        if (m_digits == 4 || cur * 10 + d > lim) begin
            push_ev(EV_ERR);
            m_digits = 0;
            return 0;
        end
        m_digits++;
        return cur * 10 + d;
    endfunction

    // Session-level keypad model: 10=ENTER 11=CLEAR 12=CANCEL 13=LANG.
    function automatic void model_key(input int k);
        if (k == 13) begin m_lang ^= 1; return; end
        if (k >= 14) return;
        case (m_phase)
            P_IDLE: if (k <= 9) begin m_phase = P_ACC; m_acc = k; m_digits = 1; end
            P_ACC, P_AMT, P_DEST: begin
                if (k <= 9) begin
                    if (m_phase == P_ACC)      m_acc  = enter_digit(m_acc, k, 4095);
                    else if (m_phase == P_AMT) m_amt  = enter_digit(m_amt, k, MAXA);
                    else                       m_dest = enter_digit(m_dest, k, 4095);
                end else if (k == 10) begin
                    if (m_digits == 0) push_ev(EV_ERR);
                    else begin
                        m_digits = 0;
                        if (m_phase == P_ACC) m_phase = P_PIN;
                        else if (m_phase == P_AMT && m_menu == 6) m_phase = P_DEST;
                        else begin m_phase = P_ISSUE; push_ev(EV_REQ); end
                    end
                end else if (k == 11) begin
                    m_digits = 0;
                    if (m_phase == P_ACC) m_acc = 0;
                    else if (m_phase == P_AMT) m_amt = 0;
                    else m_dest = 0;
                end else m_clear_all();
            end
            P_PIN: begin
                if (k <= 9) begin m_pin = k; m_digits = 1; end
                else if (k == 10) begin
                    if (m_digits == 0) push_ev(EV_ERR);
                    else begin m_digits = 0; m_phase = P_MENU; end
                end else if (k == 11) begin m_pin = 0; m_digits = 0; end
                else m_clear_all();
            end
            P_MENU: begin
                if (k == 3) begin m_menu = 3; m_phase = P_ISSUE; push_ev(EV_REQ); end
                else if (k >= 4 && k <= 7) begin m_menu = k; m_phase = P_AMT; m_digits = 0; end
                else if (k <= 9) push_ev(EV_ERR);
                else if (k == 12) m_clear_all();
            end
            default: ;
        endcase
    endfunction

    task automatic expect_ev(input int kind, input string name);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: DUT produced event %0d, expected none pending (t=%0t)", name, kind, $time);
            return;
        end
        n_checks--;
        e = exp_q.pop_front();
        check({name, "_kind"}, kind, e.kind);
        if (kind == EV_REQ && e.kind == EV_REQ) begin
            check("req_accNumber", int'(kp.accNumber), e.acc);
            check("req_pin", int'(kp.pin), e.pin);
            check("req_destinationAccNumber", int'(kp.destinationAccNumber), e.dest);
            check("req_menuOption", int'(kp.menuOption), e.menu);
            check("req_amount", int'(kp.amount), e.amt);
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                if (kp.entry_error) expect_ev(EV_ERR, "entry_error");
                if (kp.timeout) expect_ev(EV_TMO, "timeout");
                if (kp.req_valid && kp.req_ready) expect_ev(EV_REQ, "request");
            end
        end
    end

    task automatic check_fields();
        check("lang", int'(kp.lang), m_lang);
        check("accNumber", int'(kp.accNumber), m_acc);
        check("pin", int'(kp.pin), m_pin);
        check("destinationAccNumber", int'(kp.destinationAccNumber), m_dest);
        check("menuOption", int'(kp.menuOption), m_menu);
        check("amount", int'(kp.amount), m_amt);
        check("req_valid", int'(kp.req_valid), int'(m_phase == P_ISSUE));
    endtask

    task automatic send_key(input int k);
        @(negedge clk);
        kp.key_valid = 1'b1;
        kp.key_code  = 4'(k);
        model_key(k);
        @(negedge clk);
        kp.key_valid = 1'b0;
        check_fields();
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            int c;
            c = int'(s[i]);
            send_key(c >= 65 ? c - 65 + 10 : c - 48);
        end
    endtask

    task automatic handshake(input int delay);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            check("req_hold", int'(kp.req_valid), 1);
        end
        @(negedge clk);
        kp.req_ready = 1'b1;
        @(negedge clk);
        kp.req_ready = 1'b0;
        m_phase = P_WAIT;
        check("req_drop", int'(kp.req_valid), 0);
        check_fields();
    endtask

    task automatic respond(input bit err);
        @(negedge clk);
        kp.rsp_valid = 1'b1;
        kp.rsp_error = err;
        if (m_phase == P_WAIT) begin
            if (err) m_clear_all();
            else begin m_menu = 0; m_amt = 0; m_dest = 0; m_digits = 0; m_phase = P_MENU; end
        end
        @(negedge clk);
        kp.rsp_valid = 1'b0;
        kp.rsp_error = 1'b0;
        check_fields();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_req_valid_async", int'(kp.req_valid), 0);
        m_clear_all();
        m_lang = 0;
        exp_q.delete();
        check_fields();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int r, k;
        kp.key_valid = 1'b0; kp.key_code = 4'd0; kp.req_ready = 1'b0;
        kp.rsp_valid = 1'b0; kp.rsp_error = 1'b0;
        m_clear_all();
        m_lang = 0;
        repeat (3) @(negedge clk);
        check_fields();
        check("rst_entry_error", int'(kp.entry_error), 0);
        check("rst_timeout", int'(kp.timeout), 0);
        rst = 1'b0;

        send_str("2816A6A3");
        handshake(3);
        respond(1'b0);

        send_str("C4096");
        send_str("A");
        send_str("12345C");
        send_str("1A5A");
        send_str("4");
        send_str("2048");
        send_str("2047B505A");
        handshake(1);
        respond(1'b0);

        send_str("D699A3467A");
        handshake(0);
        respond(1'b1);

        send_str("1A2A");
`ifdef ATM_KEYPAD_TIMEOUT_EN
        push_ev(EV_TMO);
        repeat (TMO - 1) @(negedge clk);
        check("tmo_early", int'(kp.timeout), 0);
        @(negedge clk);
        check("tmo_pulse", int'(kp.timeout), 1);
        m_clear_all();
        check_fields();
        @(negedge clk);
        check("tmo_single", int'(kp.timeout), 0);
`else
        repeat (TMO + 50) @(negedge clk);
        check("tmo_tied", int'(kp.timeout), 0);
        send_str("3");
        handshake(2);
        respond(1'b0);
`endif

        if (m_phase == P_IDLE) send_str("1A2A");
        send_str("3");
        apply_reset();
        @(negedge clk);
        check_fields();

        for (int it = 0; it < 500; it++) begin
            if (m_phase == P_ISSUE) begin
                handshake(int'($urandom_range(0, 4)));
            end else if (m_phase == P_WAIT) begin
                if ($urandom_range(0, 2) == 0) send_key(int'($urandom_range(0, 15)));
                respond($urandom_range(0, 3) == 0);
            end else begin
                r = int'($urandom_range(0, 99));
                if (r < 60)      k = r % 10;
                else if (r < 75) k = 10;
                else if (r < 82) k = 11;
                else if (r < 86) k = 12;
                else if (r < 90) k = 13;
                else if (r < 94) k = 14 + (r % 2);
                else             k = -1;
                if (k < 0) respond($urandom_range(0, 1) == 1);
                else send_key(k);
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end

        repeat (5) @(negedge clk);
        check("pending_events", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
